// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared types and constants for the prime detector sweep checker
package prime_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] PRIME_MAP_3B = 8'hAC;
    localparam int         CODE_W       = 3;
    localparam int         MAP_W        = 8;

endpackage

// File: rtl/circuit2.sv
// rtl/circuit2.sv - 3-bit prime detector: prime is high for codes 2, 3, 5 and 7
module circuit2 (
    input  logic c,
    input  logic b,
    input  logic a,
    output logic prime
);

    assign prime = (~c & b) | (c & a);

endmodule

// File: rtl/prime_sweep_checker.sv
// rtl/prime_sweep_checker.sv - drives all eight codes into a 3-bit prime detector,
// samples its output after a settle delay and compares the map against the expected one
module prime_sweep_checker
    import prime_pkg::*;
#(
    parameter int unsigned          SETTLE   = 1,
    parameter logic [MAP_W-1:0]     EXPECTED = PRIME_MAP_3B
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prime,
    output logic [CODE_W-1:0] cba,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MAP_W-1:0]  map,
    output logic [3:0]        err_count,
    output logic              fail_valid,
    output logic [CODE_W-1:0] fail_idx
);

    localparam logic [3:0]        SETTLE_C = 4'(SETTLE);
    localparam logic [CODE_W-1:0] LAST_IDX = 3'd7;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [CODE_W-1:0] idx;
    logic              sample;
    logic              mismatch;
    logic [MAP_W-1:0]  map_next;

    assign sample   = (state == RUN) && (cnt == SETTLE_C);
    assign mismatch = (prime != EXPECTED[idx]);

    // pass is judged on the map including the sample taken this cycle
    always_comb begin
        map_next      = map;
        map_next[idx] = prime;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (sample && (idx == LAST_IDX)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign cba  = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            cnt        <= '0;
            map        <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // results from the previous sweep hold until a new one is accepted
                    if (start) begin
                        idx        <= '0;
                        cnt        <= '0;
                        map        <= '0;
                        err_count  <= '0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        fail_idx   <= '0;
                    end
                end
                RUN: begin
                    if (!sample) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        map <= map_next;
                        if (mismatch) begin
                            err_count <= err_count + 4'd1;
                            if (!fail_valid) begin
                                fail_idx   <= idx;
                                fail_valid <= 1'b1;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            pass <= (map_next == EXPECTED);
                        end else begin
                            idx <= idx + 3'd1;
                            cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_sweep_checker.sv
// tb/tb_prime_sweep_checker.sv - randomized self-checking bench for prime_sweep_checker
module tb_prime_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start_s  [2];
    logic       prime_s  [2];
    logic       det_p    [2];
    logic       use_det  [2];
    logic [7:0] src_map  [2];
    logic [2:0] cba_o    [2];
    logic       busy_o   [2];
    logic       done_o   [2];
    logic       pass_o   [2];
    logic [7:0] map_o    [2];
    logic [3:0] err_o    [2];
    logic       fv_o     [2];
    logic [2:0] fi_o     [2];

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    prime_sweep_checker #(.SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .prime(prime_s[0]),
        .cba(cba_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .map(map_o[0]), .err_count(err_o[0]), .fail_valid(fv_o[0]), .fail_idx(fi_o[0])
    );

    prime_sweep_checker #(.SETTLE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .prime(prime_s[1]),
        .cba(cba_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .map(map_o[1]), .err_count(err_o[1]), .fail_valid(fv_o[1]), .fail_idx(fi_o[1])
    );

    circuit2 u_det0 (.c(cba_o[0][2]), .b(cba_o[0][1]), .a(cba_o[0][0]), .prime(det_p[0]));
    circuit2 u_det1 (.c(cba_o[1][2]), .b(cba_o[1][1]), .a(cba_o[1][0]), .prime(det_p[1]));

    // non-detector runs replay an arbitrary truth table to emulate faulty detectors
    assign prime_s[0] = use_det[0] ? det_p[0] : src_map[0][cba_o[0]];
    assign prime_s[1] = use_det[1] ? det_p[1] : src_map[1][cba_o[1]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k < n; k++) if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] prime_table();
        logic [7:0] m;
        for (int n = 0; n < 8; n++) m[n] = is_prime(n);
        return m;
    endfunction

    task automatic check_reset_values(input int d, input string tag);
        check({tag, "_cba"},  32'(cba_o[d]),  32'd0);
        check({tag, "_busy"}, 32'(busy_o[d]), 32'd0);
        check({tag, "_done"}, 32'(done_o[d]), 32'd0);
        check({tag, "_pass"}, 32'(pass_o[d]), 32'd0);
        check({tag, "_map"},  32'(map_o[d]),  32'd0);
        check({tag, "_err"},  32'(err_o[d]),  32'd0);
        check({tag, "_fv"},   32'(fv_o[d]),   32'd0);
        check({tag, "_fi"},   32'(fi_o[d]),   32'd0);
    endtask

    // one full sweep on dut d; called right after a negedge
    task automatic run_sweep(input int d, input logic [7:0] src, input bit det, input bit poke);
        int         s1;
        int         len;
        logic [7:0] good;
        logic [7:0] obs;
        logic [7:0] diff;
        int         errs;
        int         first;
        s1   = (d == 0) ? 2 : 1;
        len  = 8 * s1;
        good = prime_table();
        obs  = det ? good : src;
        diff = obs ^ good;
        errs = 0;
        first = -1;
        for (int n = 0; n < 8; n++) begin
            if (diff[n]) begin
                errs++;
                if (first < 0) first = n;
            end
        end
        if (first < 0) first = 0;
        use_det[d] = det;
        src_map[d] = src;
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        for (int j = 0; j < len; j++) begin
            check($sformatf("d%0d_cba_j%0d", d, j), 32'(cba_o[d]), 32'(j / s1));
            check($sformatf("d%0d_busy_j%0d", d, j), 32'(busy_o[d]), 32'd1);
            check($sformatf("d%0d_done_j%0d", d, j), 32'(done_o[d]), 32'd0);
            if (poke && j == 3 * s1) start_s[d] = 1'b1;
            @(negedge clk);
            start_s[d] = 1'b0;
        end
        check($sformatf("d%0d_done_pulse", d), 32'(done_o[d]), 32'd1);
        check($sformatf("d%0d_busy_done", d), 32'(busy_o[d]), 32'd0);
        check($sformatf("d%0d_map", d), 32'(map_o[d]), 32'(obs));
        check($sformatf("d%0d_pass", d), 32'(pass_o[d]), 32'(obs == good));
        check($sformatf("d%0d_err", d), 32'(err_o[d]), 32'(errs));
        check($sformatf("d%0d_fv", d), 32'(fv_o[d]), 32'(errs != 0));
        check($sformatf("d%0d_fi", d), 32'(fi_o[d]), 32'(first));
        if (poke) start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        check($sformatf("d%0d_done_fall", d), 32'(done_o[d]), 32'd0);
        check($sformatf("d%0d_idle_busy", d), 32'(busy_o[d]), 32'd0);
        @(negedge clk);
        check($sformatf("d%0d_no_restart", d), 32'(busy_o[d]), 32'd0);
        check($sformatf("d%0d_hold_map", d), 32'(map_o[d]), 32'(obs));
        check($sformatf("d%0d_hold_err", d), 32'(err_o[d]), 32'(errs));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  waited;
        bit  found;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            use_det[i] = 1'b1;
            src_map[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_values(0, "rst0");
        check_reset_values(1, "rst1");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 8'h00, 1'b1, 1'b0);
        run_sweep(1, 8'h00, 1'b1, 1'b0);
        run_sweep(0, 8'h00, 1'b0, 1'b0);
        run_sweep(0, ~prime_table(), 1'b0, 1'b1);
        run_sweep(1, 8'h00, 1'b0, 1'b1);
        run_sweep(1, ~prime_table(), 1'b0, 1'b0);
        run_sweep(0, 8'h00, 1'b1, 1'b1);

        for (int r = 0; r < 10; r++) begin
            run_sweep(int'($urandom_range(1, 0)), 8'($urandom), bit'($urandom_range(3, 0) == 0),
                      bit'($urandom_range(1, 0)));
        end

        use_det[0] = 1'b1;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 50) begin
            if (cba_o[0] == 3'd4) found = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check("reach_cba4", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values(0, "midrst");
        repeat (2) @(negedge clk);
        check("midrst_no_done", 32'(done_o[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(busy_o[0]), 32'd0);
        run_sweep(0, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
